// File: rtl/data_memory_pipe.sv
// data_memory_pipe: word memory behind valid/ready request and response channels.
// Has a fixed read latency, byte-lane writes, error responses and credit backpressure.
module data_memory_pipe #(
  parameter int DATA_WIDTH_P = 32,
  parameter int DATA_ADDR_WIDTH_P = 32,
  parameter int DEPTH_P = 256,
  parameter int RD_LATENCY_P = 2,
  parameter int RSP_FIFO_DEPTH_P = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_req_wr,
  input  logic [DATA_ADDR_WIDTH_P-1:0] i_req_addr,
  input  logic [DATA_WIDTH_P-1:0]      i_req_wdata,
  input  logic [DATA_WIDTH_P/8-1:0]    i_req_be,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [DATA_WIDTH_P-1:0]      o_rsp_rdata,
  output logic                         o_rsp_err
);
  localparam int BE_W = DATA_WIDTH_P / 8;
  localparam int OFS_W = $clog2(BE_W);
  localparam int IW = DEPTH_P > 1 ? $clog2(DEPTH_P) : 1;
  localparam int PW = RSP_FIFO_DEPTH_P > 1 ? $clog2(RSP_FIFO_DEPTH_P) : 1;
  localparam int CW = $clog2(RSP_FIFO_DEPTH_P + 1);
  localparam logic [DATA_ADDR_WIDTH_P-1:0] OFS_MASK = DATA_ADDR_WIDTH_P'(BE_W - 1);
  localparam logic [CW-1:0] FD = CW'(RSP_FIFO_DEPTH_P);
  localparam logic [PW-1:0] LAST = PW'(RSP_FIFO_DEPTH_P - 1);

  logic [DATA_WIDTH_P-1:0] mem [DEPTH_P];
  logic [DATA_WIDTH_P-1:0] fd [RSP_FIFO_DEPTH_P];
  logic fe [RSP_FIFO_DEPTH_P];
  logic [DATA_ADDR_WIDTH_P-1:0] idx;
  logic [IW-1:0] widx;
  logic [DATA_WIDTH_P-1:0] in_d, push_d;
  logic err, accept, pop, push, push_e;
  logic [CW-1:0] cnt, fcnt;
  logic [PW-1:0] wp, rp;

  assign idx = i_req_addr >> OFS_W;
  assign widx = idx[IW-1:0];
  assign err = |(i_req_addr & OFS_MASK) || idx >= DATA_ADDR_WIDTH_P'(DEPTH_P);
  // Gating with reset keeps requests from touching the array while reset is held.
  assign o_req_ready = reset && cnt < FD;
  assign accept = i_req_valid && o_req_ready;
  assign pop = o_rsp_valid && i_rsp_ready;
  assign in_d = (i_req_wr || err) ? '0 : mem[widx];

  always_ff @(posedge clk)
    if (accept && i_req_wr && !err)
      for (int k = 0; k < BE_W; k++)
        if (i_req_be[k]) mem[widx][8*k +: 8] <= i_req_wdata[8*k +: 8];

  generate
    if (RD_LATENCY_P == 1) begin : g_direct
      assign push = accept;
      assign push_e = err;
      assign push_d = in_d;
    end else begin : g_pipe
      logic pv [RD_LATENCY_P-1];
      logic pe [RD_LATENCY_P-1];
      logic [DATA_WIDTH_P-1:0] pd [RD_LATENCY_P-1];
      always_ff @(posedge clk or negedge reset)
        if (!reset) begin
          for (int k = 0; k < RD_LATENCY_P - 1; k++) begin
            pv[k] <= 1'b0;
            pe[k] <= 1'b0;
            pd[k] <= '0;
          end
        end else begin
          pv[0] <= accept;
          pe[0] <= err;
          pd[0] <= in_d;
          for (int k = 1; k < RD_LATENCY_P - 1; k++) begin
            pv[k] <= pv[k-1];
            pe[k] <= pe[k-1];
            pd[k] <= pd[k-1];
          end
        end
      assign push = pv[RD_LATENCY_P-2];
      assign push_e = pe[RD_LATENCY_P-2];
      assign push_d = pd[RD_LATENCY_P-2];
    end
  endgenerate

  always_ff @(posedge clk)
    if (push) begin
      fd[wp] <= push_d;
      fe[wp] <= push_e;
    end

  // The outstanding count bounds FIFO occupancy, so a push never finds it full.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      fcnt <= '0;
      wp <= '0;
      rp <= '0;
    end else begin
      cnt <= cnt + CW'(accept) - CW'(pop);
      fcnt <= fcnt + CW'(push) - CW'(pop);
      if (push) wp <= wp == LAST ? '0 : wp + PW'(1);
      if (pop) rp <= rp == LAST ? '0 : rp + PW'(1);
    end

  assign o_rsp_valid = fcnt != '0;
  assign o_rsp_rdata = o_rsp_valid ? fd[rp] : '0;
  assign o_rsp_err = o_rsp_valid && fe[rp];

  a_cnt_ovf: assert property (@(posedge clk) disable iff (!reset) cnt <= FD);
  a_cnt_udf: assert property (@(posedge clk) disable iff (!reset) !(pop && cnt == '0));
  a_fifo_ovf: assert property (@(posedge clk) disable iff (!reset) !(push && !pop && fcnt == FD));
endmodule

// File: doc/data_memory_pipe.md
Name: data_memory_pipe

Overview:
Parametrised successor to the single-cycle data memory that sits beside the core. It adds:
- valid/ready request and response channels;
- a configurable read latency;
- byte-lane write enables;
- alignment and range error reporting;
- credit-based backpressure, so the core can stall on memory.

It connects to the core's data-memory interface at the top level.

Parameters:
DATA_WIDTH_P, 32, data word width; must be a multiple of 8.
DATA_ADDR_WIDTH_P, 32, byte-address width.
DEPTH_P, 256, number of words.
RD_LATENCY_P, 2, cycles from request acceptance to earliest response; must be >= 1.
RSP_FIFO_DEPTH_P, 4, maximum outstanding requests and response FIFO depth; must be >= 1. Full throughput needs >= RD_LATENCY_P+1.
(Derived: BE_W = DATA_WIDTH_P/8; OFS_W = clog2(BE_W).)

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
i_req_valid  in  1  request valid.
o_req_ready  out  1  request accepted when valid & ready.
i_req_wr  in  1  1 = write, 0 = read.
i_req_addr  in  DATA_ADDR_WIDTH_P  byte address.
i_req_wdata  in  DATA_WIDTH_P  write data.
i_req_be  in  BE_W  byte-lane write enables; bit k covers bits [8k+7:8k].
o_rsp_valid  out  1  response valid.
i_rsp_ready  in  1  response consumed when valid & ready.
o_rsp_rdata  out  DATA_WIDTH_P  read data; 0 for write or error responses.
o_rsp_err  out  1  request was misaligned or out of range.

Behaviour:
- Reset (reset = 0, asynchronous):
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0.
  - Outstanding count = 0, so o_req_ready = 1 once reset deasserts.
  - Latency pipeline and FIFO pointers cleared; in-flight requests dropped.
  - Memory array is NOT cleared; contents are retained across reset.
- Address decode:
  - word index = i_req_addr >> OFS_W.
  - Error if i_req_addr[OFS_W-1:0] != 0, or if index >= DEPTH_P.
  - An error request neither writes nor reads the array.
- Acceptance:
  - o_req_ready = (outstanding < RSP_FIFO_DEPTH_P), decoded from registered state only.
  - No combinational path from i_req_valid or i_rsp_ready to o_req_ready.
- Writes:
  - Commit at the acceptance edge, per byte lane with i_req_be set; be = 0 is a legal no-op.
  - A read accepted in the next cycle returns the new data.
- Reads: the array is sampled at the acceptance edge.
- Every accepted request, read or write, produces exactly one response, in acceptance order.
- Latency pipeline:
  - RD_LATENCY_P-stage shift of {valid, err, rdata}; stage 1 is loaded at the acceptance edge.
  - The final stage writes into the response FIFO.
  - With an empty FIFO, a request accepted in cycle T gives o_rsp_valid = 1 in cycle T+RD_LATENCY_P.
  - Response FIFO output is registered: o_rsp_* is held stable while o_rsp_valid & !i_rsp_ready.
- Outstanding counter:
  - Width clog2(RSP_FIFO_DEPTH_P+1).
  - +1 on accept, -1 on response handshake; unchanged when both occur in the same cycle.
  - Never exceeds RSP_FIFO_DEPTH_P, so the FIFO never overflows. Overflow or underflow is a bug and must be flagged by an assertion.
- Full throughput: one request per cycle is sustained indefinitely when i_rsp_ready = 1 and RSP_FIFO_DEPTH_P >= RD_LATENCY_P+1.
- Backpressure: with i_rsp_ready = 0, exactly RSP_FIFO_DEPTH_P requests are accepted, then o_req_ready = 0.
  - o_req_ready returns to 1 in the cycle after the first response handshake.
- FIFO pointers wrap modulo RSP_FIFO_DEPTH_P. Full and empty are distinguished by the count, not by pointer equality.
- Reset asserted mid-operation: all outputs go to reset values immediately; no partial response is ever emitted afterwards.
- i_req_* and i_rsp_ready are ignored while reset = 0.

Test Plan:
1. Reset -> all outputs 0 during reset; o_req_ready = 1 on the first cycle after deassert; o_rsp_valid stays 0 with no requests.
2. Write 0xDEADBEEF to 0x10 with be = 0xF in cycle T, then read 0x10 in T+1 (i_rsp_ready = 1, defaults) -> write response (err 0, rdata 0) in T+2; read response rdata 0xDEADBEEF in T+3.
3. Byte lanes: over 0xDEADBEEF, write 0x11223344 with be = 4'b0101, then read -> 0xDE22BE44. Write with be = 0, then read -> unchanged.
4. Backpressure: i_rsp_ready = 0; issue reads of 0x0, 0x4, 0x8, 0xC, 0x10 back-to-back -> 4 accepted, o_req_ready = 0 for the fifth; raise i_rsp_ready -> 4 in-order responses, data stable while stalled, then the fifth is accepted.
5. Errors: read 0x13 -> err 1, rdata 0. Write 0x400 (index 256) -> err 1. Following reads of 0x0..0x3FC show no corruption.
6. Assert reset with 3 requests in flight -> o_rsp_valid drops at once, no stale responses after release, and 0x10 still reads 0xDEADBEEF.
